// File: rtl/cpu_pkg.sv
// Shared types for the multicycle ARM sequencer.
// States, datapath select encodings and opcode constants.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        SRCA_REG = 2'b00,
        SRCA_PC  = 2'b01
    } srca_t;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } srcb_t;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_B   = 2'b10;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Counts consecutive not-ready cycles in a memory state.
// expire fires when the limit is reached and memory is still not ready.
module mem_wait_ctr #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ready,
    output logic expire
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);
    localparam logic ENABLED = (WAIT_LIMIT != 0);

    logic [CNT_W-1:0] cnt;

    assign expire = ENABLED && active && !ready && (cnt == LIMIT);

    // Leaving a memory state always happens via ready or expire,
    // so clearing on those also covers every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!active || ready || expire) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_fsm.sv
// Main sequencer of the multicycle ARM core.
// Steps FETCH/DECODE/EXECUTE/WB with a memory-ready watchdog.
module multicycle_fsm
    import cpu_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       AdrSrc,
    output srca_t      ALUSrcA,
    output srcb_t      ALUSrcB,
    output result_t    ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       Illegal,
    output logic       MemErr
);

    state_t state;
    state_t state_n;
    logic   expire;
    logic   unused_funct;

    assign unused_funct = ^Funct[4:1];

    mem_wait_ctr #(
        .WAIT_LIMIT(WAIT_LIMIT),
        .CNT_W     (CNT_W)
    ) u_wait (
        .clk   (clk),
        .rst_n (reset),
        .active(is_mem_state(state)),
        .ready (MemReady),
        .expire(expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_FETCH;
            Illegal <= 1'b0;
            MemErr  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_DECODE && Op == 2'b11) begin
                Illegal <= 1'b1;
            end
            if (expire) begin
                MemErr <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_FETCH: begin
                if (expire) begin
                    state_n = S_TRAP;
                end else if (MemReady) begin
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                case (Op)
                    OP_MEM:  state_n = S_MEMADR;
                    OP_DP:   state_n = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_B:    state_n = S_BRANCH;
                    default: state_n = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                state_n = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (expire) begin
                    state_n = S_TRAP;
                end else if (MemReady) begin
                    state_n = S_MEMWB;
                end
            end
            S_MEMWRITE: begin
                if (expire) begin
                    state_n = S_TRAP;
                end else if (MemReady) begin
                    state_n = S_FETCH;
                end
            end
            S_EXECUTER: state_n = S_ALUWB;
            S_EXECUTEI: state_n = S_ALUWB;
            S_MEMWB:    state_n = S_FETCH;
            S_ALUWB:    state_n = S_FETCH;
            S_BRANCH:   state_n = S_FETCH;
            S_TRAP:     state_n = S_TRAP;
            default:    state_n = S_FETCH;
        endcase
    end

    // FETCH strobes are gated by reset so nothing fires while held.
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        ALUOp     = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = MemReady & reset;
                NextPC    = MemReady & reset;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegW      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_EXECUTER: begin
                ALUOp = 1'b1;
            end
            S_EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                ALUOp   = 1'b1;
            end
            S_ALUWB: begin
                RegW = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                Branch    = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_fsm.sv
// Bench for multicycle_fsm: phase-sequence model plus directed
// instruction scenarios and randomized traffic.
module tb_multicycle_fsm;
    import cpu_pkg::*;

    localparam int LIMIT = 4;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite, AdrSrc, ALUOp, NextPC;
    logic       RegW, MemW, Branch, Illegal, MemErr;
    srca_t      ALUSrcA;
    srcb_t      ALUSrcB;
    result_t    ResultSrc;

    multicycle_fsm #(.WAIT_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .Op       (Op),
        .Funct    (Funct),
        .MemReady (MemReady),
        .IRWrite  (IRWrite),
        .AdrSrc   (AdrSrc),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ResultSrc(ResultSrc),
        .ALUOp    (ALUOp),
        .NextPC   (NextPC),
        .RegW     (RegW),
        .MemW     (MemW),
        .Branch   (Branch),
        .Illegal  (Illegal),
        .MemErr   (MemErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: current phase name, remaining phases of the instruction.
    string       phase = "F";
    string       pending[$];
    int          waits = 0;
    logic        m_illegal = 1'b0;
    logic        m_memerr = 1'b0;
    logic [14:0] obs;

    function automatic void model_reset();
        phase = "F";
        pending.delete();
        waits = 0;
        m_illegal = 1'b0;
        m_memerr = 1'b0;
    endfunction

    function automatic void advance(input logic [1:0] op, input logic [5:0] fn);
        if (phase == "F") begin
            phase = "D";
        end else if (phase == "D") begin
            pending.delete();
            if (op == 2'b01 && fn[0]) pending = '{"MA", "MR", "MWB"};
            else if (op == 2'b01) pending = '{"MA", "MW"};
            else if (op == 2'b00 && fn[5]) pending = '{"XI", "AWB"};
            else if (op == 2'b00) pending = '{"XR", "AWB"};
            else if (op == 2'b10) pending = '{"B"};
            if (op == 2'b11) begin
                m_illegal = 1'b1;
                phase = "T";
            end else begin
                phase = pending.pop_front();
            end
        end else if (pending.size() > 0) begin
            phase = pending.pop_front();
        end else begin
            phase = "F";
        end
    endfunction

    function automatic void model_step(input logic mr, input logic [1:0] op,
                                       input logic [5:0] fn);
        if (phase == "T") return;
        if (phase == "F" || phase == "MR" || phase == "MW") begin
            if (mr) begin
                waits = 0;
                advance(op, fn);
            end else if (LIMIT != 0 && waits == LIMIT) begin
                m_memerr = 1'b1;
                waits = 0;
                phase = "T";
            end else begin
                waits++;
            end
        end else begin
            advance(op, fn);
        end
    endfunction

    // {IRWrite,AdrSrc,SrcA,SrcB,Result,ALUOp,NextPC,RegW,MemW,Branch,Illegal,MemErr}
    function automatic logic [14:0] expect_vec(input logic r, input logic mr);
        logic irw, adr, alop, npc, rw, mw, br;
        logic [1:0] a, b, res;
        irw = 0; adr = 0; alop = 0; npc = 0; rw = 0; mw = 0; br = 0;
        a = 0; b = 0; res = 0;
        if (!r || phase == "F" || phase == "D") begin
            a = 2'b01; b = 2'b10; res = 2'b10;
            irw = r && phase == "F" && mr;
            npc = irw;
        end else if (phase == "MA") begin
            b = 2'b01;
        end else if (phase == "MR") begin
            adr = 1;
        end else if (phase == "MWB") begin
            res = 2'b01; rw = 1;
        end else if (phase == "MW") begin
            adr = 1; mw = 1;
        end else if (phase == "XR") begin
            alop = 1;
        end else if (phase == "XI") begin
            b = 2'b01; alop = 1;
        end else if (phase == "AWB") begin
            rw = 1;
        end else if (phase == "B") begin
            b = 2'b01; res = 2'b10; br = 1;
        end
        return {irw, adr, a, b, res, alop, npc, rw, mw, br, m_illegal, m_memerr};
    endfunction

    task automatic lit(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic mr, input logic [1:0] op,
                       input logic [5:0] fn);
        logic [14:0] exp;
        @(negedge clk);
        reset = r; MemReady = mr; Op = op; Funct = fn;
        if (!r) model_reset();
        #1;
        obs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               NextPC, RegW, MemW, Branch, Illegal, MemErr};
        exp = expect_vec(r, mr);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL outputs phase=%s t=%0t: got %b want %b",
                     phase, $time, obs, exp);
        end
        @(posedge clk);
        if (r) model_step(mr, op, fn);
    endtask

    localparam logic [5:0] F_LDR = 6'b011001;
    localparam logic [5:0] F_STR = 6'b011000;
    localparam logic [5:0] F_ADI = 6'b101000;

    initial begin
        int n;
        logic [4:0] v5;
        logic [5:0] v6;
        logic [2:0] v3;
        logic [1:0] op;
        logic [5:0] fn;
        logic r, mr;
        reset = 0; MemReady = 1; Op = 0; Funct = 0;

        cyc(0, 1, 2'b01, F_LDR);
        cyc(0, 1, 2'b01, F_LDR);
        lit("reset_strobes", {obs[14], obs[5:2]}, 0);
        v5 = '0;
        cyc(1, 1, 2'b01, F_LDR);
        lit("irw_after_reset", {obs[14], obs[5]}, 3);
        v5[0] = obs[4];
        for (int i = 1; i < 5; i++) begin
            cyc(1, 1, 2'b01, F_LDR);
            v5[i] = obs[4];
        end
        lit("ldr_regw", v5, 5'b10000);
        lit("ldr_result", obs[8:7], 1);

        cyc(1, 1, 2'b01, F_STR);
        lit("ldr_5_cycles", obs[14], 1);
        n = 0;
        cyc(1, 1, 2'b01, F_STR); n += obs[3];
        cyc(1, 1, 2'b01, F_STR); n += obs[3];
        for (int i = 0; i < 4; i++) begin
            cyc(1, i == 3, 2'b01, F_STR);
            n += obs[3];
        end
        lit("str_memw_cycles", n, 4);

        cyc(1, 1, 2'b00, F_ADI);
        lit("str_back_fetch", obs[14], 1);
        cyc(1, 1, 2'b00, F_ADI);
        cyc(1, 1, 2'b00, F_ADI);
        lit("addi_exec", {obs[10:9], obs[6]}, 3'b011);
        cyc(1, 1, 2'b00, F_ADI);
        lit("addi_wb", obs[4], 1);

        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 2'b10, 6'b0);
            v3[i] = obs[2];
        end
        lit("b_branch", v3, 3'b100);
        cyc(1, 1, 2'b11, 6'b0);
        lit("b_3_cycles", obs[14], 1);

        cyc(1, 1, 2'b11, 6'b0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 2'b11, 6'b0);
            if (obs[1] && obs[14] == 0 && obs[5:2] == 0) n++;
        end
        lit("trap_hold", n, 20);

        cyc(0, 1, 2'b00, 6'b0);
        lit("reset_clears_illegal", obs[1], 0);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 2'b00, 6'b0);
            v6[i] = obs[0];
        end
        lit("wdog_memerr", v6, 6'b100000);

        cyc(0, 1, 2'b01, F_STR);
        cyc(1, 1, 2'b01, F_STR);
        cyc(1, 1, 2'b01, F_STR);
        cyc(1, 1, 2'b01, F_STR);
        cyc(1, 0, 2'b01, F_STR);
        lit("mw_before_reset", obs[3], 1);
        cyc(0, 0, 2'b01, F_STR);
        lit("mw_drops_on_reset", obs[3], 0);

        op = 2'b00; fn = 6'b0;
        for (int i = 0; i < 3000; i++) begin
            if (phase == "F") begin
                op = ($urandom % 10 == 0) ? 2'b11 : 2'($urandom % 3);
                fn = 6'($urandom);
            end
            mr = ($urandom_range(0, 99) < 85);
            if (phase == "T") r = ($urandom % 8 != 0);
            else r = ($urandom % 150 != 0);
            cyc(r, mr, op, fn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
